// File: rtl/mem_arbiter.sv
// Single-port memory sequencer/arbiter for panel, IO and PU requesters (fixed priority pnl > io > pu).
// Latency: grant in IDLE, strobe next cycle, ack in the cycle the memory reply arrives, rd_data valid the cycle after.
// Backpressure: requests are level-held and wait while busy; optional WAIT timeout enabled by MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pu_req,
  input  logic [11:0] pu_addr,
  output logic        pu_ack,
  input  logic        pnl_req,
  input  logic        pnl_we,
  input  logic [11:0] pnl_addr,
  input  logic        pnl_wsign,
  input  logic [29:0] pnl_wdata,
  output logic        pnl_ack,
  input  logic        io_req,
  input  logic [11:0] io_addr,
  input  logic        io_wsign,
  input  logic [29:0] io_wdata,
  output logic        io_ack,
  output logic        rd_sign,
  output logic [29:0] rd_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [11:0] mem_addr,
  output logic        mem_wsign,
  output logic [29:0] mem_wdata,
  input  logic        mem_read_reply,
  input  logic        mem_write_reply,
  input  logic        mem_rsign,
  input  logic [29:0] mem_rdata,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;
  typedef enum logic [1:0] {OWN_PU, OWN_PNL, OWN_IO} owner_t;

  state_t      state, state_nxt;
  owner_t      owner, owner_nxt;
  logic        op_wr, op_wr_nxt;
  logic [11:0] addr_q, addr_nxt;
  logic        wsign_q, wsign_nxt;
  logic [29:0] wdata_q, wdata_nxt;
  logic        rd_sign_nxt;
  logic [29:0] rd_data_nxt;
  logic        done;
  logic        reply_match;
  logic        tmo_hit;

  assign reply_match = op_wr ? mem_write_reply : mem_read_reply;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       tmo_err_q;
  logic       timed_out;

  if (TIMEOUT_CYCLES < 3 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be in 3..255");
  end

  assign tmo_hit   = (state == WAIT) && (tmo_cnt == 8'(TIMEOUT_CYCLES));
  assign timed_out = tmo_hit && !reply_match;

  // Cleared while in ISSUE so the first WAIT cycle counts from zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tmo_cnt   <= 8'd0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state == ISSUE)
        tmo_cnt <= 8'd0;
      else if (state == WAIT)
        tmo_cnt <= tmo_cnt + 8'd1;
      if (timed_out)
        tmo_err_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    op_wr_nxt   = op_wr;
    addr_nxt    = addr_q;
    wsign_nxt   = wsign_q;
    wdata_nxt   = wdata_q;
    rd_sign_nxt = rd_sign;
    rd_data_nxt = rd_data;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (pnl_req) begin
          owner_nxt = OWN_PNL;
          op_wr_nxt = pnl_we;
          addr_nxt  = pnl_addr;
          wsign_nxt = pnl_wsign;
          wdata_nxt = pnl_wdata;
          state_nxt = ISSUE;
        end else if (io_req) begin
          owner_nxt = OWN_IO;
          op_wr_nxt = 1'b1;
          addr_nxt  = io_addr;
          wsign_nxt = io_wsign;
          wdata_nxt = io_wdata;
          state_nxt = ISSUE;
        end else if (pu_req) begin
          owner_nxt = OWN_PU;
          op_wr_nxt = 1'b0;
          addr_nxt  = pu_addr;
          wsign_nxt = 1'b0;
          wdata_nxt = 30'd0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (reply_match) begin
          done      = 1'b1;
          state_nxt = RELEASE;
          if (!op_wr) begin
            rd_sign_nxt = mem_rsign;
            rd_data_nxt = mem_rdata;
          end
        end else if (tmo_hit) begin
          done      = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      owner   <= OWN_PU;
      op_wr   <= 1'b0;
      addr_q  <= 12'd0;
      wsign_q <= 1'b0;
      wdata_q <= 30'd0;
      rd_sign <= 1'b0;
      rd_data <= 30'd0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      op_wr   <= op_wr_nxt;
      addr_q  <= addr_nxt;
      wsign_q <= wsign_nxt;
      wdata_q <= wdata_nxt;
      rd_sign <= rd_sign_nxt;
      rd_data <= rd_data_nxt;
    end
  end

  // Strobes and acks are masked during reset so an aborted op never completes.
  assign mem_read  = resetn && (state == ISSUE) && !op_wr;
  assign mem_write = resetn && (state == ISSUE) && op_wr;
  assign mem_addr  = addr_q;
  assign mem_wsign = wsign_q;
  assign mem_wdata = wdata_q;
  assign pu_ack    = resetn && done && (owner == OWN_PU);
  assign pnl_ack   = resetn && done && (owner == OWN_PNL);
  assign io_ack    = resetn && done && (owner == OWN_IO);
  assign busy      = (state != IDLE);

endmodule
